// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache fill
// path and the D-cache fill/write-back path. Each requester owns a one-deep
// request slot; the FSM walks IDLE -> ISSUE -> WAIT -> RESP per transaction
// and returns the result on the originating cache's registered rec_* port.
module mem_arbiter #(
    parameter int PADDR_W = 20,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_req_ren,
    input  logic [PADDR_W-1:0] i_req_addr,
    output logic               i_rec_en,
    output logic [PADDR_W-1:0] i_rec_addr,
    output logic [LINE_W-1:0]  i_rec_cacheline,

    input  logic               d_req_ren,
    input  logic               d_req_wen,
    input  logic [PADDR_W-1:0] d_req_addr,
    input  logic [LINE_W-1:0]  d_req_data,
    output logic               d_rec_en,
    output logic [PADDR_W-1:0] d_rec_addr,
    output logic [LINE_W-1:0]  d_rec_cacheline,

    output logic               mem_ren,
    output logic               mem_wen,
    output logic [PADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [LINE_W-1:0]  mem_rdata,

    output logic               busy,
    output logic               err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // request slots
    logic               i_slot_vld;
    logic [PADDR_W-1:0] i_slot_addr;
    logic               d_slot_vld;
    logic               d_slot_wen;
    logic [PADDR_W-1:0] d_slot_addr;
    logic [LINE_W-1:0]  d_slot_data;

    // one-cycle shadows of the line just returned to each cache
    logic               i_shd_vld;
    logic [PADDR_W-1:0] i_shd_addr;
    logic               d_shd_vld;
    logic [PADDR_W-1:0] d_shd_addr;

    logic               ptr_d;      // 0: I side has priority, 1: D side
    logic               gnt_d;      // side owning the current transaction
    logic               gnt_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               resp_go;
    logic               tmo;

    logic               d_req_any;
    logic               i_cap;
    logic               d_cap;
    logic               sel_wen;
    logic [PADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0]  sel_wdata;
    logic [LINE_W-1:0]  rsp_data;

    // A cache keeps its registered request up one cycle after the fill;
    // the shadow stops that stale request from being captured again.
    assign d_req_any = d_req_ren | d_req_wen;
    assign i_cap = i_req_ren && !i_slot_vld &&
                   !(i_shd_vld && (i_shd_addr == i_req_addr));
    assign d_cap = d_req_any && !d_slot_vld &&
                   !(d_shd_vld && (d_shd_addr == d_req_addr));

    assign sel_wen   = gnt_nxt & d_slot_wen;
    assign sel_addr  = gnt_nxt ? d_slot_addr : i_slot_addr;
    assign sel_wdata = sel_wen ? d_slot_data : '0;

    // Write-backs and timeouts return an all-zero line.
    assign rsp_data = (mem_ack && !(gnt_d && d_slot_wen)) ? mem_rdata : '0;

    assign busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, grant selection and timeout detection
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_d;
        tmo       = 1'b0;
        resp_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_slot_vld && d_slot_vld) begin
                    gnt_nxt   = ptr_d;
                    state_nxt = S_ISSUE;
                end else if (i_slot_vld) begin
                    gnt_nxt   = 1'b0;
                    state_nxt = S_ISSUE;
                end else if (d_slot_vld) begin
                    gnt_nxt   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = mem_ack ? S_RESP : S_WAIT;
                resp_go   = mem_ack;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_nxt = S_RESP;
                    resp_go   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_RESP;
                    resp_go   = 1'b1;
                    tmo       = 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Slot capture; the granted slot is freed on leaving RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_slot_vld  <= 1'b0;
            i_slot_addr <= '0;
            d_slot_vld  <= 1'b0;
            d_slot_wen  <= 1'b0;
            d_slot_addr <= '0;
            d_slot_data <= '0;
        end else begin
            if (state == S_RESP && !gnt_d) begin
                i_slot_vld <= 1'b0;
            end else if (i_cap) begin
                i_slot_vld  <= 1'b1;
                i_slot_addr <= i_req_addr;
            end
            if (state == S_RESP && gnt_d) begin
                d_slot_vld <= 1'b0;
            end else if (d_cap) begin
                d_slot_vld  <= 1'b1;
                d_slot_wen  <= d_req_wen;
                d_slot_addr <= d_req_addr;
                d_slot_data <= d_req_data;
            end
        end
    end

    // Grant owner, round-robin pointer and shadows armed on RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_d      <= 1'b0;
            ptr_d      <= 1'b0;
            i_shd_vld  <= 1'b0;
            i_shd_addr <= '0;
            d_shd_vld  <= 1'b0;
            d_shd_addr <= '0;
        end else begin
            gnt_d     <= gnt_nxt;
            i_shd_vld <= 1'b0;
            d_shd_vld <= 1'b0;
            if (state == S_RESP) begin
                ptr_d <= ~gnt_d;
                if (gnt_d) begin
                    d_shd_vld  <= 1'b1;
                    d_shd_addr <= d_slot_addr;
                end else begin
                    i_shd_vld  <= 1'b1;
                    i_shd_addr <= i_slot_addr;
                end
            end
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (tmo) begin
            err <= 1'b1;
        end
    end

    // Memory command: loaded on grant, held through WAIT, dropped on response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == S_IDLE && state_nxt == S_ISSUE) begin
            mem_ren   <= ~sel_wen;
            mem_wen   <= sel_wen;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
        end else if (resp_go) begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end
    end

    // WAIT cycle counter, cleared while issuing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered response strobes; everything reads zero outside the pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rec_en        <= 1'b0;
            i_rec_addr      <= '0;
            i_rec_cacheline <= '0;
            d_rec_en        <= 1'b0;
            d_rec_addr      <= '0;
            d_rec_cacheline <= '0;
        end else begin
            i_rec_en        <= 1'b0;
            i_rec_addr      <= '0;
            i_rec_cacheline <= '0;
            d_rec_en        <= 1'b0;
            d_rec_addr      <= '0;
            d_rec_cacheline <= '0;
            if (resp_go) begin
                if (gnt_d) begin
                    d_rec_en        <= 1'b1;
                    d_rec_addr      <= d_slot_addr;
                    d_rec_cacheline <= rsp_data;
                end else begin
                    i_rec_en        <= 1'b1;
                    i_rec_addr      <= i_slot_addr;
                    i_rec_cacheline <= rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed/randomised bench for mem_arbiter with a behavioural memory model
// (associative line store with configurable ack latency) and a round-robin
// expectation kept as plain per-side bookkeeping.
module tb_mem_arbiter;

    localparam int PADDR_W = 20;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_req_ren;
    logic [PADDR_W-1:0] i_req_addr;
    logic               i_rec_en;
    logic [PADDR_W-1:0] i_rec_addr;
    logic [LINE_W-1:0]  i_rec_cacheline;
    logic               d_req_ren;
    logic               d_req_wen;
    logic [PADDR_W-1:0] d_req_addr;
    logic [LINE_W-1:0]  d_req_data;
    logic               d_rec_en;
    logic [PADDR_W-1:0] d_rec_addr;
    logic [LINE_W-1:0]  d_rec_cacheline;
    logic               mem_ren;
    logic               mem_wen;
    logic [PADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic               mem_ack;
    logic [LINE_W-1:0]  mem_rdata;
    logic               busy;
    logic               err;

    always #5 clk = ~clk;

    mem_arbiter #(.PADDR_W(PADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req_ren(i_req_ren), .i_req_addr(i_req_addr),
        .i_rec_en(i_rec_en), .i_rec_addr(i_rec_addr), .i_rec_cacheline(i_rec_cacheline),
        .d_req_ren(d_req_ren), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data),
        .d_rec_en(d_rec_en), .d_rec_addr(d_rec_addr), .d_rec_cacheline(d_rec_cacheline),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    int nvec = 0;
    int nerr = 0;

    // memory model
    logic [LINE_W-1:0]  mem_store [logic [PADDR_W-1:0]];
    int                 mem_lat;
    bit                 lat_rand;
    int                 mem_age;
    bit                 cmd_live;
    logic               cmd_wen;
    logic [PADDR_W-1:0] cmd_addr;
    logic [LINE_W-1:0]  cmd_wdata;

    // per-test statistics
    int n_cmd, ren_cyc, wen_cyc, i_rec_n, d_rec_n;

    // results of wait_rec and round-robin bookkeeping
    int                 lat;
    bit                 side;
    logic [PADDR_W-1:0] raddr;
    logic [LINE_W-1:0]  rdata;
    int                 alt_n;
    bit                 exp_side;
    int                 i_cd, d_cd;
    logic [LINE_W-1:0]  pat_a5;

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [PADDR_W-1:0] new_addr(input logic [PADDR_W-1:0] old);
        logic [PADDR_W-1:0] a;
        a = PADDR_W'($urandom);
        if (a == old) a = a ^ PADDR_W'(1);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_cmd = 0; ren_cyc = 0; wen_cyc = 0; i_rec_n = 0; d_rec_n = 0;
    endtask

    // One clock: advance, then play the memory and watch the rec ports.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_ren || mem_wen) begin
            if (!cmd_live) begin
                cmd_live  = 1'b1;
                n_cmd++;
                cmd_wen   = mem_wen;
                cmd_addr  = mem_addr;
                cmd_wdata = mem_wdata;
                mem_age   = 0;
                if (lat_rand) mem_lat = int'($urandom_range(0, 3));
                chk("cmd_onehot", 160'({mem_ren, mem_wen}), 160'(cmd_wen ? 2'b01 : 2'b10));
                if (!mem_wen) chk("rd_wdata_zero", 160'(mem_wdata), 160'(0));
            end else begin
                chk("cmd_stable", 160'({mem_wen, mem_ren, mem_addr, mem_wdata}),
                    160'({cmd_wen, ~cmd_wen, cmd_addr, cmd_wdata}));
            end
            if (mem_ren) ren_cyc++; else wen_cyc++;
            mem_ack   = (mem_lat >= 0) && (mem_age == mem_lat);
            mem_rdata = rnd_line();
            if (mem_ack) begin
                if (mem_wen) begin
                    mem_store[mem_addr] = mem_wdata;
                end else begin
                    if (!mem_store.exists(mem_addr)) mem_store[mem_addr] = rnd_line();
                    mem_rdata = mem_store[mem_addr];
                end
            end
            mem_age++;
        end else begin
            cmd_live  = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = rnd_line();
        end
        if (i_rec_en) i_rec_n++;
        else chk("i_rec_idle_zero", 160'({i_rec_addr, i_rec_cacheline}), 160'(0));
        if (d_rec_en) d_rec_n++;
        else chk("d_rec_idle_zero", 160'({d_rec_addr, d_rec_cacheline}), 160'(0));
    endtask

    task automatic wait_rec(input string tag, input int budget);
        bit seen;
        seen  = 1'b0;
        lat   = 0;
        side  = 1'b0;
        raddr = '0;
        rdata = '0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            lat++;
            if (i_rec_en || d_rec_en) begin
                seen  = 1'b1;
                side  = d_rec_en;
                raddr = d_rec_en ? d_rec_addr : i_rec_addr;
                rdata = d_rec_en ? d_rec_cacheline : i_rec_cacheline;
            end
        end
        nvec++;
        assert (seen) else begin
            nerr++;
            $error("FAIL %s: no rec strobe within %0d cycles (observed none, expected one)", tag, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        i_req_ren = 1'b0; i_req_addr = '0;
        d_req_ren = 1'b0; d_req_wen = 1'b0; d_req_addr = '0; d_req_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        mem_lat = 0; lat_rand = 1'b0; mem_age = 0; cmd_live = 1'b0;
        pat_a5 = {16{8'hA5}};
        clr_stats();

        // reset state
        repeat (2) tick();
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_err", 160'(err), 160'(0));
        chk("rst_mem_cmd", 160'({mem_ren, mem_wen}), 160'(0));
        chk("rst_mem_addr", 160'(mem_addr), 160'(0));
        chk("rst_mem_wdata", 160'(mem_wdata), 160'(0));
        chk("rst_rec_en", 160'({i_rec_en, d_rec_en}), 160'(0));
        rst = 1'b1;
        tick();
        chk("post_rst_busy", 160'(busy), 160'(0));

        // I and D raised together; expect strict alternation starting with I
        clr_stats();
        lat_rand = 1'b1;
        i_req_addr = new_addr(20'h0);
        d_req_addr = new_addr(i_req_addr);
        i_req_ren = 1'b1;
        d_req_ren = 1'b1;
        alt_n = 0; exp_side = 1'b0; i_cd = 0; d_cd = 0;
        for (int k = 0; k < 300 && alt_n < 10; k++) begin
            tick();
            if (i_cd > 0) begin
                i_cd--;
                if (i_cd == 0) i_req_addr = new_addr(i_req_addr);
            end
            if (d_cd > 0) begin
                d_cd--;
                if (d_cd == 0) d_req_addr = new_addr(d_req_addr);
            end
            if (i_rec_en || d_rec_en) begin
                chk("alt_side", 160'({i_rec_en, d_rec_en}), 160'(exp_side ? 2'b01 : 2'b10));
                if (d_rec_en) begin
                    chk("alt_d_addr", 160'(d_rec_addr), 160'(d_req_addr));
                    chk("alt_d_data", 160'(d_rec_cacheline), 160'(mem_store[d_req_addr]));
                    d_cd = 2;
                end else begin
                    chk("alt_i_addr", 160'(i_rec_addr), 160'(i_req_addr));
                    chk("alt_i_data", 160'(i_rec_cacheline), 160'(mem_store[i_req_addr]));
                    i_cd = 2;
                end
                exp_side = ~exp_side;
                alt_n++;
            end
        end
        chk("alt_count", 160'(alt_n), 160'(10));
        i_req_ren = 1'b0;
        d_req_ren = 1'b0;
        lat_rand = 1'b0;
        mem_lat = 0;
        repeat (20) tick();
        chk("alt_drain_idle", 160'(busy), 160'(0));

        // single I read, memory acks 4 cycles after the command
        clr_stats();
        mem_lat = 4;
        i_req_addr = 20'h00400;
        i_req_ren = 1'b1;
        wait_rec("i_read", 40);
        chk("i_read_side", 160'(side), 160'(0));
        chk("i_read_addr", 160'(raddr), 160'(20'h00400));
        chk("i_read_data", 160'(rdata), 160'(mem_store[20'h00400]));
        chk("i_read_latency", 160'(lat), 160'(7));
        chk("i_read_ren_cycles", 160'(ren_cyc), 160'(5));
        // cache keeps the same request up one more cycle
        tick();
        tick();
        i_req_ren = 1'b0;
        repeat (8) tick();
        chk("shadow_same_ncmd", 160'(n_cmd), 160'(1));
        chk("i_read_one_rec", 160'(i_rec_n), 160'(1));
        chk("i_read_no_d_rec", 160'(d_rec_n), 160'(0));

        // held request with a new address right after the fill
        clr_stats();
        mem_lat = 1;
        i_req_addr = 20'h00C00;
        i_req_ren = 1'b1;
        wait_rec("shadow_first", 20);
        chk("shadow_first_addr", 160'(raddr), 160'(20'h00C00));
        tick();
        i_req_addr = 20'h00800;
        tick();
        i_req_ren = 1'b0;
        wait_rec("shadow_new", 20);
        chk("shadow_new_side", 160'(side), 160'(0));
        chk("shadow_new_addr", 160'(raddr), 160'(20'h00800));
        chk("shadow_new_data", 160'(rdata), 160'(mem_store[20'h00800]));
        repeat (6) tick();
        chk("shadow_new_ncmd", 160'(n_cmd), 160'(2));

        // D write-back
        clr_stats();
        lat_rand = 1'b1;
        d_req_addr = 20'h01230;
        d_req_data = pat_a5;
        d_req_wen = 1'b1;
        wait_rec("d_write", 20);
        chk("d_write_side", 160'(side), 160'(1));
        chk("d_write_addr", 160'(raddr), 160'(20'h01230));
        chk("d_write_data_zero", 160'(rdata), 160'(0));
        chk("d_write_no_read", 160'(ren_cyc), 160'(0));
        chk("d_write_cmd_wen", 160'(cmd_wen), 160'(1));
        chk("d_write_cmd_addr", 160'(cmd_addr), 160'(20'h01230));
        chk("d_write_cmd_wdata", 160'(cmd_wdata), 160'(pat_a5));
        tick();
        tick();
        d_req_wen = 1'b0;
        repeat (4) tick();
        chk("d_write_ncmd", 160'(n_cmd), 160'(1));
        chk("d_write_no_i_rec", 160'(i_rec_n), 160'(0));

        // read the written line back through the I side
        clr_stats();
        i_req_addr = 20'h01230;
        i_req_ren = 1'b1;
        wait_rec("readback", 20);
        chk("readback_data", 160'(rdata), 160'(pat_a5));
        tick();
        tick();
        i_req_ren = 1'b0;
        repeat (4) tick();
        lat_rand = 1'b0;
        chk("err_before_timeout", 160'(err), 160'(0));

        // memory never acks
        clr_stats();
        mem_lat = -1;
        i_req_addr = 20'h00500;
        i_req_ren = 1'b1;
        wait_rec("timeout", 100);
        chk("timeout_side", 160'(side), 160'(0));
        chk("timeout_addr", 160'(raddr), 160'(20'h00500));
        chk("timeout_data_zero", 160'(rdata), 160'(0));
        chk("timeout_ren_cycles", 160'(ren_cyc), 160'(TIMEOUT + 1));
        chk("timeout_latency", 160'(lat), 160'(TIMEOUT + 3));
        chk("timeout_err", 160'(err), 160'(1));
        tick();
        tick();
        i_req_ren = 1'b0;
        repeat (3) tick();

        // next request proceeds, err stays up
        clr_stats();
        mem_lat = 2;
        i_req_addr = 20'h00600;
        i_req_ren = 1'b1;
        wait_rec("after_timeout", 20);
        chk("after_timeout_addr", 160'(raddr), 160'(20'h00600));
        chk("after_timeout_data", 160'(rdata), 160'(mem_store[20'h00600]));
        chk("after_timeout_latency", 160'(lat), 160'(5));
        chk("after_timeout_err", 160'(err), 160'(1));
        tick();
        tick();
        i_req_ren = 1'b0;
        repeat (3) tick();

        // reset pulled during WAIT
        clr_stats();
        mem_lat = -1;
        d_req_addr = 20'h00700;
        d_req_ren = 1'b1;
        for (int k = 0; k < 10 && !mem_ren; k++) tick();
        chk("rm_issue", 160'(mem_ren), 160'(1));
        repeat (3) tick();
        chk("rm_busy_before", 160'(busy), 160'(1));
        rst = 1'b0;
        d_req_ren = 1'b0;
        #1;
        chk("rm_busy", 160'(busy), 160'(0));
        chk("rm_mem_cmd", 160'({mem_ren, mem_wen}), 160'(0));
        chk("rm_mem_addr", 160'(mem_addr), 160'(0));
        chk("rm_err_cleared", 160'(err), 160'(0));
        chk("rm_rec_en", 160'({i_rec_en, d_rec_en}), 160'(0));
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rm_no_rec", 160'(i_rec_n + d_rec_n), 160'(0));
        chk("rm_idle", 160'(busy), 160'(0));

        // fresh request after reset
        clr_stats();
        mem_lat = 1;
        i_req_addr = 20'h00400;
        i_req_ren = 1'b1;
        wait_rec("post_reset", 20);
        chk("post_reset_side", 160'(side), 160'(0));
        chk("post_reset_addr", 160'(raddr), 160'(20'h00400));
        chk("post_reset_data", 160'(rdata), 160'(mem_store[20'h00400]));
        chk("post_reset_latency", 160'(lat), 160'(4));
        chk("post_reset_err", 160'(err), 160'(0));
        tick();
        tick();
        i_req_ren = 1'b0;
        repeat (4) tick();
        chk("post_reset_ncmd", 160'(n_cmd), 160'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
